fetch_prefetch_buffer: RTL and testbench

FETCH_PREFETCH_BUFFER -- requirements
Module: fetch_prefetch_buffer

---
 rtl/fetch_prefetch_buffer.sv | 155 +++++++++++++++
 tb/tb_fetch_prefetch_buffer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer
//   Instruction prefetcher. It issues word-aligned fetch requests to an
//   instruction memory with a req/gnt + rvalid protocol and queues the
//   returned {instruction, pc} pairs in a small FIFO for the decoder.
//   The number of granted-but-unanswered requests is limited, and the
//   FIFO always has room for every outstanding response.
//   A branch flushes the FIFO, redirects fetch, and marks in-flight
//   responses for discard.
// Ports
//   clk, rst_n              clock, async active-low reset
//   fetch_en_i              leave IDLE and start fetching at pc_start_addr_i
//   branch_i/branch_addr_i  redirect strobe and target
//   instr_req_o/addr_o      memory request (held stable until instr_gnt_i)
//   instr_gnt_i             request accepted
//   instr_rvalid_i/rdata_i  in-order response
//   fetch_valid_o/instr_o/pc_o  FIFO head; popped on fetch_ready_i
//   busy_o                  RUN, or responses still owed by memory
module fetch_prefetch_buffer #(
  parameter int WORD_WIDTH      = 32,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en_i,
  input  logic [WORD_WIDTH-1:0] pc_start_addr_i,
  input  logic                  branch_i,
  input  logic [WORD_WIDTH-1:0] branch_addr_i,
  output logic                  instr_req_o,
  output logic [WORD_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [WORD_WIDTH-1:0] instr_rdata_i,
  output logic                  fetch_valid_o,
  output logic [WORD_WIDTH-1:0] fetch_instr_o,
  output logic [WORD_WIDTH-1:0] fetch_pc_o,
  input  logic                  fetch_ready_i,
  output logic                  busy_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [WORD_WIDTH-1:0] STEP = WORD_WIDTH'(4);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state_q;
  logic [WORD_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [WORD_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [WORD_WIDTH-1:0] hold_addr_q;
  logic                  hold_q, hold_d;
  logic                  stale_q, stale_d;
  logic [OW-1:0]         outs_q, outs_d;
  logic [OW-1:0]         disc_q, disc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [WORD_WIDTH-1:0] instr_mem [DEPTH];
  logic [WORD_WIDTH-1:0] pc_mem    [DEPTH];

  logic run, flush, gnt_fire, rv_fire, push, pop, credit_ok;

  assign run       = (state_q == RUN);
  assign flush     = run && branch_i;
  assign credit_ok = (int'(cnt_q) + int'(outs_q) < DEPTH) && (int'(outs_q) < MAX_OUTSTANDING);

  // A request that was not yet granted keeps its original address, even
  // across a branch; fetch_addr_q may already point at the new target.
  assign instr_req_o  = run && (hold_q || credit_ok);
  assign instr_addr_o = hold_q ? hold_addr_q : fetch_addr_q;

  assign gnt_fire = instr_req_o && instr_gnt_i;
  // Responses with nothing outstanding (stray) are ignored.
  assign rv_fire  = run && instr_rvalid_i && (outs_q != '0);
  assign push     = rv_fire && (disc_q == '0) && !branch_i;
  assign pop      = fetch_valid_o && fetch_ready_i;

  assign fetch_valid_o = (cnt_q != '0);
  assign fetch_instr_o = fetch_valid_o ? instr_mem[rptr_q] : '0;
  assign fetch_pc_o    = fetch_valid_o ? pc_mem[rptr_q]    : '0;
  assign busy_o        = run || (outs_q != '0) || (disc_q != '0);

  always_comb begin
    outs_d = outs_q;
    if (gnt_fire && !rv_fire)      outs_d = outs_q + 1'b1;
    else if (!gnt_fire && rv_fire) outs_d = outs_q - 1'b1;

    disc_d = disc_q;
    if (rv_fire && disc_q != '0) disc_d = disc_q - 1'b1;
    // A pre-branch request granted after the branch is owed a discard slot.
    if (gnt_fire && stale_q)     disc_d = disc_d + 1'b1;
    if (flush)                   disc_d = outs_d;

    cnt_d = cnt_q;
    if (flush)              cnt_d = '0;
    else if (push && !pop)  cnt_d = cnt_q + 1'b1;
    else if (!push && pop)  cnt_d = cnt_q - 1'b1;

    fetch_addr_d = fetch_addr_q;
    resp_pc_d    = resp_pc_q;
    if (!run && fetch_en_i) begin
      fetch_addr_d = {pc_start_addr_i[WORD_WIDTH-1:2], 2'b00};
      resp_pc_d    = {pc_start_addr_i[WORD_WIDTH-1:2], 2'b00};
    end else if (flush) begin
      fetch_addr_d = {branch_addr_i[WORD_WIDTH-1:2], 2'b00};
      resp_pc_d    = {branch_addr_i[WORD_WIDTH-1:2], 2'b00};
    end else begin
      if (gnt_fire && !stale_q) fetch_addr_d = fetch_addr_q + STEP;
      if (push)                 resp_pc_d    = resp_pc_q + STEP;
    end

    hold_d  = instr_req_o && !instr_gnt_i;
    stale_d = hold_d && (stale_q || flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      resp_pc_q    <= '0;
      hold_addr_q  <= '0;
      hold_q       <= 1'b0;
      stale_q      <= 1'b0;
      outs_q       <= '0;
      disc_q       <= '0;
      cnt_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
    end else begin
      if (!run && fetch_en_i) state_q <= RUN;
      fetch_addr_q <= fetch_addr_d;
      resp_pc_q    <= resp_pc_d;
      hold_q       <= hold_d;
      stale_q      <= stale_d;
      if (hold_d) hold_addr_q <= instr_addr_o;
      outs_q <= outs_d;
      disc_q <= disc_d;
      cnt_q  <= cnt_d;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wptr_q] <= instr_rdata_i;
      pc_mem[wptr_q]    <= resp_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Testbench for fetch_prefetch_buffer: directed scenarios plus a randomized
// run against a memory model whose data is a bijective hash of the address
// and an expected in-order pc stream that restarts at each branch target.
module tb_fetch_prefetch_buffer;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_en_i = 1'b0;
  logic [31:0] pc_start_addr_i = '0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        fetch_valid_o;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic        fetch_ready_i = 1'b0;
  logic        busy_o;

  always #5 clk = ~clk;

  fetch_prefetch_buffer #(.WORD_WIDTH(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en_i), .pc_start_addr_i(pc_start_addr_i),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i), .instr_req_o(instr_req_o),
    .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i), .fetch_valid_o(fetch_valid_o), .fetch_instr_o(fetch_instr_o),
    .fetch_pc_o(fetch_pc_o), .fetch_ready_i(fetch_ready_i), .busy_o(busy_o)
  );

  int checks = 0, passed = 0;
  int gnt_pct, rv_pct, rdy_pct;
  bit stray = 1'b0;
  int hold_viol = 0, outs_viol = 0;
  bit prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] memq[$], glog[$], ppc[$], pin[$];

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // One clock cycle as the memory and consumer see it. Called at posedge+1.
  task automatic step(input bit br, input logic [31:0] baddr);
    logic [31:0] a;
    if (prev_hold && (instr_req_o !== 1'b1 || instr_addr_o !== prev_addr)) hold_viol++;
    if (memq.size() > MAXO) outs_viol++;
    branch_i      = br;
    branch_addr_i = baddr;
    instr_gnt_i   = instr_req_o && ($urandom_range(0, 99) < gnt_pct);
    if (stray) begin
      instr_rvalid_i = 1'b1; instr_rdata_i = $urandom;
    end else if (memq.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
      a = memq.pop_front(); instr_rvalid_i = 1'b1; instr_rdata_i = hash(a);
    end else begin
      instr_rvalid_i = 1'b0; instr_rdata_i = $urandom;
    end
    fetch_ready_i = !br && ($urandom_range(0, 99) < rdy_pct);
    if (instr_req_o && instr_gnt_i) begin memq.push_back(instr_addr_o); glog.push_back(instr_addr_o); end
    if (fetch_valid_o && fetch_ready_i) begin ppc.push_back(fetch_pc_o); pin.push_back(fetch_instr_o); end
    prev_hold = instr_req_o && !instr_gnt_i;
    prev_addr = instr_addr_o;
    @(posedge clk); #1;
    branch_i = 1'b0;
  endtask

  task automatic clear_model();
    fetch_en_i = 0; branch_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0; fetch_ready_i = 0; stray = 0;
    memq.delete(); glog.delete(); ppc.delete(); pin.delete(); prev_hold = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic boot(input logic [31:0] a);
    pc_start_addr_i = a; fetch_en_i = 1'b1;
    step(1'b0, '0);
    fetch_en_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear_model();
    @(posedge clk); #1;
    checks++; if (instr_req_o !== 1'b0) $display("FAIL reset_req got %0b want 0", instr_req_o); else passed++;
    checks++; if (instr_addr_o !== 32'h0) $display("FAIL reset_addr got %h want 0", instr_addr_o); else passed++;
    checks++; if (fetch_valid_o !== 1'b0) $display("FAIL reset_valid got %0b want 0", fetch_valid_o); else passed++;
    checks++; if (fetch_instr_o !== 32'h0) $display("FAIL reset_instr got %h want 0", fetch_instr_o); else passed++;
    checks++; if (fetch_pc_o !== 32'h0) $display("FAIL reset_pc got %h want 0", fetch_pc_o); else passed++;
    checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy_o); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (instr_req_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL idle_quiet got req=%0b busy=%0b want 0/0", instr_req_o, busy_o); else passed++;
  endtask

  task automatic test_boot();
    do_reset(); gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    boot(32'h100);
    for (int i = 0; i < 12; i++) step(1'b0, '0);
    checks++;
    if (glog.size() < 4) $display("FAIL boot_grants got %0d want >=4", glog.size());
    else begin
      passed++;
      for (int i = 0; i < 4; i++) begin
        checks++; if (glog[i] !== 32'h100 + 32'(4 * i))
          $display("FAIL boot_addr%0d got %h want %h", i, glog[i], 32'h100 + 32'(4 * i)); else passed++;
      end
    end
    checks++;
    if (ppc.size() < 2) $display("FAIL boot_pops got %0d want >=2", ppc.size());
    else begin
      passed++;
      checks++; if (ppc[0] !== 32'h100) $display("FAIL boot_pc0 got %h want 100", ppc[0]); else passed++;
      checks++; if (pin[0] !== hash(32'h100)) $display("FAIL boot_instr0 got %h want %h", pin[0], hash(32'h100)); else passed++;
      checks++; if (ppc[1] !== 32'h104) $display("FAIL boot_pc1 got %h want 104", ppc[1]); else passed++;
    end
  endtask

  task automatic test_backpressure();
    do_reset(); gnt_pct = 100; rv_pct = 100; rdy_pct = 0;
    boot(32'h100);
    for (int i = 0; i < 15; i++) step(1'b0, '0);
    checks++; if (glog.size() != DEPTH) $display("FAIL bp_grants got %0d want %0d", glog.size(), DEPTH); else passed++;
    checks++; if (instr_req_o !== 1'b0) $display("FAIL bp_req got %0b want 0", instr_req_o); else passed++;
    checks++; if (fetch_valid_o !== 1'b1 || fetch_pc_o !== 32'h100 || fetch_instr_o !== hash(32'h100))
      $display("FAIL bp_head got v=%0b pc=%h want 1/100", fetch_valid_o, fetch_pc_o); else passed++;
    rdy_pct = 100; step(1'b0, '0);
    rdy_pct = 0;
    for (int i = 0; i < 6; i++) step(1'b0, '0);
    checks++; if (ppc.size() != 1) $display("FAIL bp_pops got %0d want 1", ppc.size()); else passed++;
    checks++; if (glog.size() != DEPTH + 1) $display("FAIL bp_refill got %0d want %0d", glog.size(), DEPTH + 1);
    else begin
      passed++;
      checks++; if (glog[DEPTH] !== 32'h110) $display("FAIL bp_refill_addr got %h want 110", glog[DEPTH]); else passed++;
    end
    checks++; if (instr_req_o !== 1'b0 || fetch_pc_o !== 32'h104)
      $display("FAIL bp_after got req=%0b pc=%h want 0/104", instr_req_o, fetch_pc_o); else passed++;
  endtask

  task automatic test_stall_hold();
    do_reset(); gnt_pct = 0; rv_pct = 100; rdy_pct = 100;
    boot(32'h100);
    for (int i = 0; i < 5; i++) begin
      checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h100)
        $display("FAIL stall_hold%0d got req=%0b addr=%h want 1/100", i, instr_req_o, instr_addr_o); else passed++;
      step(1'b0, '0);
    end
    gnt_pct = 100; step(1'b0, '0);
    checks++; if (glog.size() != 1 || instr_addr_o !== 32'h104)
      $display("FAIL stall_release got grants=%0d addr=%h want 1/104", glog.size(), instr_addr_o); else passed++;
  endtask

  task automatic test_flush();
    int gi, pi, n;
    do_reset(); gnt_pct = 100; rv_pct = 100; rdy_pct = 0;
    boot(32'h100);
    for (int i = 0; i < 15; i++) step(1'b0, '0);
    rv_pct = 0; rdy_pct = 100;
    step(1'b0, '0); step(1'b0, '0);
    rdy_pct = 0; n = 0;
    while (memq.size() < 2 && n < 10) begin step(1'b0, '0); n++; end
    checks++; if (memq.size() != 2 || fetch_pc_o !== 32'h108)
      $display("FAIL flush_setup got outstanding=%0d pc=%h want 2/108", memq.size(), fetch_pc_o); else passed++;
    gi = glog.size();
    step(1'b1, 32'h203);
    pi = ppc.size();
    checks++; if (fetch_valid_o !== 1'b0) $display("FAIL flush_empty got %0b want 0", fetch_valid_o); else passed++;
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    for (int i = 0; i < 12; i++) step(1'b0, '0);
    checks++;
    if (ppc.size() < pi + 2 || glog.size() <= gi) $display("FAIL flush_progress got pops=%0d grants=%0d", ppc.size() - pi, glog.size() - gi);
    else begin
      passed++;
      checks++; if (glog[gi] !== 32'h200) $display("FAIL flush_req got %h want 200", glog[gi]); else passed++;
      checks++; if (ppc[pi] !== 32'h200 || pin[pi] !== hash(32'h200))
        $display("FAIL flush_first got pc=%h instr=%h want 200/%h", ppc[pi], pin[pi], hash(32'h200)); else passed++;
      checks++; if (ppc[pi+1] !== 32'h204) $display("FAIL flush_second got %h want 204", ppc[pi+1]); else passed++;
    end
  endtask

  task automatic test_branch_ungranted();
    int gi, pi, n;
    bit found;
    do_reset(); gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    boot(32'h100);
    found = 0; n = 0;
    while (!found && n < 20) begin
      if (instr_req_o && instr_addr_o == 32'h108) found = 1;
      else begin step(1'b0, '0); n++; end
    end
    checks++; if (!found) $display("FAIL bu_reach got none want req at 108"); else passed++;
    gnt_pct = 0; gi = glog.size();
    step(1'b1, 32'h400);
    pi = ppc.size();
    for (int i = 0; i < 3; i++) begin
      checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h108)
        $display("FAIL bu_hold%0d got req=%0b addr=%h want 1/108", i, instr_req_o, instr_addr_o); else passed++;
      step(1'b0, '0);
    end
    gnt_pct = 100;
    for (int i = 0; i < 12; i++) step(1'b0, '0);
    checks++;
    if (glog.size() < gi + 2 || ppc.size() <= pi) $display("FAIL bu_progress got grants=%0d pops=%0d", glog.size() - gi, ppc.size() - pi);
    else begin
      passed++;
      checks++; if (glog[gi] !== 32'h108) $display("FAIL bu_old_grant got %h want 108", glog[gi]); else passed++;
      checks++; if (glog[gi+1] !== 32'h400) $display("FAIL bu_target_req got %h want 400", glog[gi+1]); else passed++;
      checks++; if (ppc[pi] !== 32'h400 || pin[pi] !== hash(32'h400))
        $display("FAIL bu_first got pc=%h instr=%h want 400/%h", ppc[pi], pin[pi], hash(32'h400)); else passed++;
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    do_reset(); gnt_pct = 100; rv_pct = 100; rdy_pct = 0;
    boot(32'h100);
    for (int i = 0; i < 3; i++) step(1'b0, '0);
    rv_pct = 0; n = 0;
    while (memq.size() < 2 && n < 10) begin step(1'b0, '0); n++; end
    checks++; if (memq.size() != 2 || fetch_valid_o !== 1'b1)
      $display("FAIL mr_setup got outstanding=%0d valid=%0b want 2/1", memq.size(), fetch_valid_o); else passed++;
    #2; rst_n = 1'b0; #1;
    checks++; if ({instr_req_o, instr_addr_o, fetch_valid_o, fetch_instr_o, fetch_pc_o, busy_o} !== '0)
      $display("FAIL mr_async got req=%0b addr=%h v=%0b instr=%h pc=%h busy=%0b want all 0",
               instr_req_o, instr_addr_o, fetch_valid_o, fetch_instr_o, fetch_pc_o, busy_o); else passed++;
    clear_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
    stray = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0);
      checks++; if (fetch_valid_o !== 1'b0 || busy_o !== 1'b0)
        $display("FAIL mr_stray%0d got valid=%0b busy=%0b want 0/0", i, fetch_valid_o, busy_o); else passed++;
    end
    stray = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp, p, d, t;
    int delivered;
    bit br;
    do_reset(); gnt_pct = 60; rv_pct = 60; rdy_pct = 60;
    t = $urandom;
    boot(t);
    exp = {t[31:2], 2'b00};
    delivered = 0;
    for (int c = 0; c < 1600; c++) begin
      if (c == 1500) begin gnt_pct = 100; rv_pct = 100; rdy_pct = 100; end
      br = (c < 1500) && ($urandom_range(0, 99) < 3);
      while (ppc.size() > 0) begin
        p = ppc.pop_front(); d = pin.pop_front();
        checks++;
        if (p !== exp || d !== hash(exp))
          $display("FAIL rand_pop got pc=%h instr=%h want %h/%h", p, d, exp, hash(exp));
        else passed++;
        exp += 32'd4; delivered++;
      end
      if (br) begin
        t = $urandom;
        step(1'b1, t);
        exp = {t[31:2], 2'b00};
      end else step(1'b0, '0);
    end
    checks++; if (delivered < 100) $display("FAIL rand_volume got %0d want >=100", delivered); else passed++;
    checks++; if (hold_viol != 0) $display("FAIL req_hold got %0d violations want 0", hold_viol); else passed++;
    checks++; if (outs_viol != 0) $display("FAIL outstanding_limit got %0d violations want 0", outs_viol); else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_boot();
    test_backpressure();
    test_stall_hold();
    test_flush();
    test_branch_ungranted();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
